// File: rtl/cordic_arbiter.sv
// cordic_arbiter: round-robin issue of two requesters into a fixed-latency cordic core, with tagged result return
module cordic_arbiter #(
  parameter int W = 16,
  parameter int LATENCY = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         req0_valid,
  input  logic         req1_valid,
  output logic         req0_ready,
  output logic         req1_ready,
  input  logic         req0_mode,
  input  logic         req1_mode,
  input  logic [W-1:0] req0_x,
  input  logic [W-1:0] req0_y,
  input  logic [W-1:0] req0_z,
  input  logic [W-1:0] req1_x,
  input  logic [W-1:0] req1_y,
  input  logic [W-1:0] req1_z,
  output logic         core_mode,
  output logic [W-1:0] core_x,
  output logic [W-1:0] core_y,
  output logic [W-1:0] core_z,
  input  logic [W-1:0] core_res1,
  input  logic [W-1:0] core_res2,
  output logic         out_valid,
  output logic         out_id,
  output logic [W-1:0] out_res1,
  output logic [W-1:0] out_res2,
  output logic         busy,
  output logic [15:0]  done_cnt
);
  localparam int CW = $clog2(LATENCY + 2);
  logic               ptr;
  logic               issue;
  logic               gid;
  logic               sel_mode;
  logic [LATENCY-1:0] tag_v;
  logic [LATENCY-1:0] tag_id;
  logic [CW-1:0]      inflight;
  assign req0_ready = reset & en & req0_valid & (~req1_valid | ~ptr);
  assign req1_ready = reset & en & req1_valid & (~req0_valid | ptr);
  assign issue = req0_ready | req1_ready;
  assign gid = req1_ready;
  assign sel_mode = gid ? req1_mode : req0_mode;
  assign busy = inflight != '0;
  // an op counts as in flight until its out_valid cycle has been presented
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= 1'b0;
      core_mode <= 1'b0;
      core_x <= '0;
      core_y <= '0;
      core_z <= '0;
      tag_v <= '0;
      tag_id <= '0;
      out_valid <= 1'b0;
      out_id <= 1'b0;
      out_res1 <= '0;
      out_res2 <= '0;
      inflight <= '0;
      done_cnt <= '0;
    end else begin
      if (issue) begin
        ptr <= ~gid;
        core_mode <= sel_mode;
        core_x <= gid ? req1_x : req0_x;
        core_y <= gid ? req1_y : req0_y;
        core_z <= sel_mode ? '0 : (gid ? req1_z : req0_z);
      end
      for (int i = LATENCY - 1; i > 0; i--) begin
        tag_v[i] <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
      tag_v[0] <= issue;
      tag_id[0] <= gid;
      out_valid <= tag_v[LATENCY-1];
      if (tag_v[LATENCY-1]) begin
        out_id <= tag_id[LATENCY-1];
        out_res1 <= core_res1;
        out_res2 <= core_res2;
      end
      inflight <= inflight + CW'(issue) - CW'(out_valid);
      done_cnt <= done_cnt + 16'(out_valid);
    end
  end
endmodule

// File: doc/cordic_arbiter.md
CORDIC_ARBITER -- requirements
Module: cordic_arbiter

Interface
REQ-001 SHALL have parameter W, default 16: data width of x, y, z and results.
REQ-002 SHALL have parameter LATENCY, default 16: fixed pipeline latency of the cordic core, in cycles, minimum 1.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port en, input, 1: issue enable; low blocks new grants.
REQ-006 SHALL have ports reqN_valid, input, 1 (N=0,1): requester N has an operation pending.
REQ-007 SHALL have ports reqN_ready, output, 1: combinational grant to requester N.
REQ-008 SHALL have ports reqN_mode, input, 1: 0 = rotation (uses z), 1 = vectoring (z ignored).
REQ-009 SHALL have ports reqN_x, reqN_y, reqN_z, input, W each: operands.
REQ-010 SHALL have ports core_mode (1), core_x, core_y, core_z (W each), output: registered drive to the cordic core.
REQ-011 SHALL have ports core_res1, core_res2, input, W each: core outputs.
REQ-012 SHALL have ports out_valid (1), out_id (1), out_res1, out_res2 (W each), output: registered result and originating requester.
REQ-013 SHALL have port busy, output, 1: high while any operation is in flight.
REQ-014 SHALL have port done_cnt, output, 16: count of completed operations.

Function
REQ-015 An issue SHALL occur at an edge where en=1 and the granted reqN_valid=1; reqN_ready=1 and reqN_valid=1 form the handshake.
REQ-016 At most one ready SHALL be high per cycle; ready SHALL never be high while en=0.
REQ-017 With only one valid requester, that requester SHALL be granted the same cycle.
REQ-018 With both valid, the requester named by a 1-bit round-robin pointer SHALL be granted; the pointer SHALL move to the other requester after every issue.
REQ-019 The pointer SHALL not change on cycles without an issue.
REQ-020 On issue at edge E0, core_mode/core_x/core_y SHALL load the granted operands; core_z SHALL load reqN_z for mode 0 and 0 for mode 1.
REQ-021 Without an issue, core_* SHALL hold their values.
REQ-022 A valid/id tag shift register of LATENCY stages SHALL advance every cycle; a stage entering at E0 reaches the end at edge E0+LATENCY.
REQ-023 At edge E0+LATENCY, out_valid SHALL be 1 for one cycle, with out_id = issuing requester and out_res1/out_res2 = core_res1/core_res2 sampled at that edge.
REQ-024 Back-to-back issues SHALL be accepted every cycle; results SHALL emerge in issue order, one per cycle, with no backpressure.
REQ-025 An in-flight counter SHALL increment on issue, decrement on completion, and stay unchanged on a simultaneous issue and completion; busy = (counter != 0).
REQ-026 done_cnt SHALL increment on each out_valid and wrap from 0xFFFF to 0.
REQ-027 en falling SHALL stop new issues only; in-flight operations SHALL still complete.
REQ-028 out_res1/out_res2 SHALL hold their last values when out_valid=0.

Reset
REQ-029 reset=0 SHALL immediately clear core_*, out_*, tag stages, in-flight counter, done_cnt, busy, and the pointer (pointer to requester 0), with no clock required.
REQ-030 Operations in flight at reset SHALL be discarded and no out_valid produced for them.
REQ-031 reqN_ready SHALL be 0 while reset=0.
REQ-032 Issues SHALL be possible at the first rising edge after reset returns high.

Verification
REQ-033 Single op: req0 mode0 x=0x26DD y=0 z=0x2000, en=1 -> core_* loaded next edge; out_valid exactly LATENCY cycles later, out_id=0, out_res = core_res at that edge; done_cnt=1.
REQ-034 Contention: both valid continuously for 6 cycles -> grants 0,1,0,1,0,1; results out_id 0,1,0,1,0,1 on consecutive cycles; busy falls one cycle after the last out_valid.
REQ-035 Vectoring: req1 mode1 x=0x1000 y=0x1000 z=0x7FFF -> core_z=0, core_mode=1.
REQ-036 en=0 with both requesters valid for 10 cycles -> no ready and pointer unchanged; ops in flight before en fell still produce out_valid.
REQ-037 reset asserted mid-flight with 3 ops pending -> outputs 0 immediately; no out_valid after release; first post-release grant goes to req0.
REQ-038 2^16 completions -> done_cnt wraps to 0.
